traffic_phase_controller: RTL and testbench

- Consumer end of the 1 Hz enable pulse produced by the clock divider.
- Sequences a two-road intersection (north-south / east-west) with a latched pedestrian request, timing every phase in enable ticks, never in raw clocks.
- Drives the lamp outputs and the walk signal.
- Tick source and this block share the single system clock.

---
 rtl/traffic_phase_controller_pkg.sv | 13 +
 rtl/traffic_phase_controller_phase_timer.sv | 23 ++
 rtl/traffic_phase_controller.sv | 73 +++++++
 tb/tb_traffic_phase_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_controller_pkg.sv
// traffic_phase_controller_pkg: shared state codes, lamp patterns and tick counter width
package traffic_phase_controller_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED   = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] PED_WALK  = 3'd5;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// phase_timer: counts enable ticks within a phase and flags the final tick
module phase_timer
  import traffic_phase_controller_pkg::*;
(
  input  logic             clk,
  input  logic             global_reset,
  input  logic             tick,
  input  logic [CNT_W-1:0] duration,
  input  logic             restart,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // expire on the tick that completes the phase; count clears for the next one
  always_comb begin
    expire = tick && (cnt_q == duration - CNT_W'(1));
    cnt_d  = (expire || restart) ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // tick counter register
  always_ff @(posedge clk) begin
    if (!global_reset) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: two-road intersection sequencer with latched pedestrian phase
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4
) (
  input  logic       clk,
  input  logic       global_reset,
  input  logic       enable_1Hz,
  input  logic       ped_request,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);
  logic [2:0]       state_q, state_d;
  logic             next_dir_q, next_dir_d;
  logic             ped_q, ped_d;
  logic [CNT_W-1:0] dur;
  logic             expire, illegal;
  phase_timer u_timer (
    .clk          (clk),
    .global_reset (global_reset),
    .tick         (enable_1Hz),
    .duration     (dur),
    .restart      (illegal),
    .expire       (expire)
  );
  // phase duration select and next-state logic; illegal codes recover via all-red
  always_comb begin
    illegal    = state_q > PED_WALK;
    dur        = (state_q == NS_GREEN  || state_q == EW_GREEN)  ? CNT_W'(GREEN_TICKS)  :
                 (state_q == NS_YELLOW || state_q == EW_YELLOW) ? CNT_W'(YELLOW_TICKS) :
                 (state_q == PED_WALK)                          ? CNT_W'(WALK_TICKS)   :
                                                                  CNT_W'(ALLRED_TICKS);
    state_d    = state_q;
    next_dir_d = next_dir_q;
    if (illegal) state_d = ALL_RED;
    else if (expire) begin
      case (state_q)
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: begin state_d = ALL_RED; next_dir_d = 1'b1; end
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: begin state_d = ALL_RED; next_dir_d = 1'b0; end
        ALL_RED:   state_d = ped_q ? PED_WALK : next_dir_q ? EW_GREEN : NS_GREEN;
        default:   state_d = next_dir_q ? EW_GREEN : NS_GREEN;
      endcase
    end
    ped_d = (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 : ped_q | ped_request;
  end
  // state, direction and pedestrian latch registers
  always_ff @(posedge clk) begin
    if (!global_reset) begin
      state_q    <= NS_GREEN;
      next_dir_q <= 1'b1;
      ped_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      ped_q      <= ped_d;
    end
  end
  // lamp decode straight from the state register
  always_comb begin
    ns_light = state_q == NS_GREEN ? GREEN : state_q == NS_YELLOW ? YELLOW : RED;
    ew_light = state_q == EW_GREEN ? GREEN : state_q == EW_YELLOW ? YELLOW : RED;
    walk     = state_q == PED_WALK;
    phase    = state_q;
  end
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: scoreboard bench checking phase order, durations and lamps
module tb_traffic_phase_controller;
  logic       clk = 0;
  logic       global_reset = 0;
  logic       enable_1Hz = 0;
  logic       ped_request = 0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;
  int         checks = 0;
  int         fails = 0;
  bit         armed = 0;
  typedef struct {
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       w;
    int         dur;
  } entry_t;
  entry_t exp_q[$];
  traffic_phase_controller dut (
    .clk          (clk),
    .global_reset (global_reset),
    .enable_1Hz   (enable_1Hz),
    .ped_request  (ped_request),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .walk         (walk),
    .phase        (phase)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
        fails++;
        $display("FAIL lamp_safety t=%0t ns=%b ew=%b required one road red", $time, ns_light, ew_light);
      end
      checks++;
      if (walk === 1'b1 && (ns_light !== 3'b100 || ew_light !== 3'b100)) begin
        fails++;
        $display("FAIL walk_safety t=%0t ns=%b ew=%b required both 100", $time, ns_light, ew_light);
      end
    end
  end
  task automatic push(input logic [2:0] ph, input int dur);
    entry_t e;
    e.ph  = ph;
    e.ns  = ph == 3'd0 ? 3'b001 : ph == 3'd1 ? 3'b010 : 3'b100;
    e.ew  = ph == 3'd3 ? 3'b001 : ph == 3'd4 ? 3'b010 : 3'b100;
    e.w   = ph == 3'd5;
    e.dur = dur;
    exp_q.push_back(e);
  endtask
  task automatic run_seq(input int period, input bit hold, output int total);
    entry_t e;
    int n;
    total = 0;
    if (hold) enable_1Hz = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || ns_light !== e.ns || ew_light !== e.ew || walk !== e.w) begin
        fails++;
        $display("FAIL phase_entry got ph=%0d ns=%b ew=%b walk=%b required ph=%0d ns=%b ew=%b walk=%b",
                 phase, ns_light, ew_light, walk, e.ph, e.ns, e.ew, e.w);
      end
      n = 0;
      while (phase === e.ph && n < 300) begin
        if (!hold) enable_1Hz = 1;
        @(negedge clk);
        if (!hold) enable_1Hz = 0;
        n++;
        repeat (period - 1) @(negedge clk);
      end
      checks++;
      if (n !== e.dur) begin
        fails++;
        $display("FAIL phase_duration ph=%0d got %0d ticks required %0d", e.ph, n, e.dur);
      end
      total += n;
    end
    enable_1Hz = 0;
  endtask
  task automatic do_tick();
    enable_1Hz = 1;
    @(negedge clk);
    enable_1Hz = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic apply_reset();
    global_reset = 0;
    @(negedge clk);
    global_reset = 1;
    armed = 1;
  endtask
  task automatic test_reset();
    apply_reset();
    checks++;
    if (phase !== 3'd0 || ns_light !== 3'b001 || ew_light !== 3'b100 || walk !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got ph=%0d ns=%b ew=%b walk=%b required 0 001 100 0", phase, ns_light, ew_light, walk);
    end
    checks++;
    if (dut.u_timer.cnt_q !== 8'd0 || dut.ped_q !== 1'b0 || dut.next_dir_q !== 1'b1) begin
      fails++;
      $display("FAIL reset_regs got cnt=%0d ped=%b dir=%b required 0 0 1", dut.u_timer.cnt_q, dut.ped_q, dut.next_dir_q);
    end
  endtask
  task automatic test_nominal();
    int t;
    apply_reset();
    push(0, 5); push(1, 2); push(2, 1); push(3, 5); push(4, 2); push(2, 1); push(0, 5);
    run_seq(4, 0, t);
    checks++;
    if (t !== 21) begin
      fails++;
      $display("FAIL nominal_total got %0d ticks required 21", t);
    end
  endtask
  task automatic test_ped_pulse();
    int t;
    apply_reset();
    push(0, 5); push(1, 2); push(2, 1);
    run_seq(4, 0, t);
    ped_request = 1;
    @(negedge clk);
    ped_request = 0;
    push(3, 5); push(4, 2); push(2, 1); push(5, 4);
    run_seq(4, 0, t);
    checks++;
    if (dut.ped_q !== 1'b0) begin
      fails++;
      $display("FAIL ped_cleared got %b required 0", dut.ped_q);
    end
    push(0, 5); push(1, 2); push(2, 1); push(3, 5);
    run_seq(4, 0, t);
  endtask
  task automatic test_reset_mid();
    int t;
    apply_reset();
    push(0, 5); push(1, 2); push(2, 1);
    run_seq(4, 0, t);
    do_tick();
    do_tick();
    apply_reset();
    checks++;
    if (phase !== 3'd0 || ns_light !== 3'b001 || ew_light !== 3'b100 || dut.u_timer.cnt_q !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid got ph=%0d ns=%b ew=%b cnt=%0d required 0 001 100 0", phase, ns_light, ew_light, dut.u_timer.cnt_q);
    end
    push(0, 5); push(1, 2);
    run_seq(4, 0, t);
  endtask
  task automatic test_back_to_back();
    int t;
    apply_reset();
    push(0, 5); push(1, 2); push(2, 1); push(3, 5); push(4, 2); push(2, 1);
    run_seq(1, 1, t);
    checks++;
    if (t !== 16 || phase !== 3'd0) begin
      fails++;
      $display("FAIL continuous_cycle got %0d clks ph=%0d required 16 clks ph=0", t, phase);
    end
  endtask
  task automatic test_ped_held();
    int t;
    apply_reset();
    ped_request = 1;
    push(0, 5); push(1, 2); push(2, 1);
    run_seq(4, 0, t);
    checks++;
    if (phase !== 3'd5) begin
      fails++;
      $display("FAIL ped_held_walk1 got ph=%0d required 5", phase);
    end
    @(negedge clk);
    checks++;
    if (dut.ped_q !== 1'b1) begin
      fails++;
      $display("FAIL ped_held_latched got %b required 1", dut.ped_q);
    end
    push(5, 4); push(3, 5); push(4, 2); push(2, 1); push(5, 4);
    run_seq(4, 0, t);
    ped_request = 0;
    push(0, 5);
    run_seq(4, 0, t);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_nominal();
    test_ped_pulse();
    test_reset_mid();
    test_back_to_back();
    test_ped_held();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
